// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC unit: FSM states, redirect causes, PC step.
package npc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        DSLOT
    } npc_state_t;

    typedef enum logic [2:0] {
        SEQ,
        BR,
        JMP,
        REG,
        EXC
    } npc_cause_t;

    localparam int unsigned PC_STEP = 4;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational target generator: computes sequential, branch, jump, register and exception
// targets and picks one by fixed priority (exception > taken branch > J/JAL > JR/JALR > sequential).
module npc_target_calc
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] exc_addr,
    input  logic            br_beq,
    input  logic            br_bne,
    input  logic            br_bgez,
    input  logic            zf,
    input  logic            sf,
    input  logic            j_j,
    input  logic            j_jal,
    input  logic            j_jr,
    input  logic            j_jalr,
    input  logic            exc_req,
    output logic [XLEN-1:0] sel_tgt,
    output npc_cause_t      cause
);

    logic [XLEN-1:0] seq_tgt;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jmp_tgt;
    logic            taken;
    logic            unused_opcode;

    assign unused_opcode = ^inst[31:26];

    assign taken   = (br_beq & zf) | (br_bne & ~zf) | (br_bgez & (zf | ~sf));
    assign seq_tgt = pc + XLEN'(PC_STEP);
    assign br_tgt  = seq_tgt + {{(XLEN-18){inst[15]}}, inst[15:0], 2'b00};
    assign jmp_tgt = {pc[XLEN-1:28], inst[25:0], 2'b00};

    always_comb begin
        cause   = SEQ;
        sel_tgt = seq_tgt;
        if (exc_req) begin
            cause   = EXC;
            sel_tgt = exc_addr;
        end else if (taken) begin
            cause   = BR;
            sel_tgt = br_tgt;
        end else if (j_j | j_jal) begin
            cause   = JMP;
            sel_tgt = jmp_tgt;
        end else if (j_jr | j_jalr) begin
            cause   = REG;
            sel_tgt = rs_val;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator owning the PC register, with pending-redirect capture while the PC is held.
// Optional delay-slot behaviour is enabled by defining NPC_DELAY_SLOT_EN.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] exc_addr,
    input  logic            br_beq,
    input  logic            br_bne,
    input  logic            br_bgez,
    input  logic            zf,
    input  logic            sf,
    input  logic            j_j,
    input  logic            j_jal,
    input  logic            j_jr,
    input  logic            j_jalr,
    input  logic            exc_req,
    input  logic            if_ack,
    output logic [XLEN-1:0] pc_o,
    output logic            if_req,
    output logic            redirect_o,
    output logic            misalign_o
);

    npc_state_t      state;
    npc_cause_t      sel_cause;
    logic [XLEN-1:0] sel_tgt;
    logic [XLEN-1:0] pend_tgt;
    logic            pend_vld;
    logic            pend_is_exc;
    logic            advance;
    logic [XLEN-1:0] merged_tgt;
    logic            merged_vld;
    logic            merged_is_exc;
`ifdef NPC_DELAY_SLOT_EN
    logic [XLEN-1:0] ds_tgt;
`endif

    npc_target_calc #(.XLEN(XLEN)) u_target_calc (
        .pc       (pc_o),
        .inst     (inst),
        .rs_val   (rs_val),
        .exc_addr (exc_addr),
        .br_beq   (br_beq),
        .br_bne   (br_bne),
        .br_bgez  (br_bgez),
        .zf       (zf),
        .sf       (sf),
        .j_j      (j_j),
        .j_jal    (j_jal),
        .j_jr     (j_jr),
        .j_jalr   (j_jalr),
        .exc_req  (exc_req),
        .sel_tgt  (sel_tgt),
        .cause    (sel_cause)
    );

    assign advance = if_ack & ~stall & (state != BOOT);

    // A stored redirect beats the current one, except that an exception replaces a stored non-exception target.
    always_comb begin
        merged_vld    = 1'b0;
        merged_is_exc = 1'b0;
        merged_tgt    = sel_tgt;
        if (pend_vld) begin
            merged_vld = 1'b1;
            if (exc_req && !pend_is_exc) begin
                merged_is_exc = 1'b1;
                merged_tgt    = exc_addr;
            end else begin
                merged_is_exc = pend_is_exc;
                merged_tgt    = pend_tgt;
            end
        end else if (sel_cause != SEQ) begin
            merged_vld    = 1'b1;
            merged_is_exc = (sel_cause == EXC);
            merged_tgt    = sel_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc_o        <= XLEN'(RESET_VEC);
            if_req      <= 1'b0;
            redirect_o  <= 1'b0;
            misalign_o  <= 1'b0;
            pend_vld    <= 1'b0;
            pend_is_exc <= 1'b0;
            pend_tgt    <= '0;
`ifdef NPC_DELAY_SLOT_EN
            ds_tgt      <= '0;
`endif
        end else begin
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                BOOT: begin
                    state  <= RUN;
                    if_req <= 1'b1;
                end
                RUN, HOLD: begin
                    if (advance) begin
                        pend_vld    <= 1'b0;
                        pend_is_exc <= 1'b0;
                        state       <= RUN;
`ifdef NPC_DELAY_SLOT_EN
                        if (merged_vld && !merged_is_exc) begin
                            pc_o   <= pc_o + XLEN'(PC_STEP);
                            ds_tgt <= merged_tgt;
                            state  <= DSLOT;
                        end else begin
                            pc_o       <= merged_tgt;
                            redirect_o <= merged_vld;
                            misalign_o <= merged_vld && is_misaligned(merged_tgt[1:0]);
                        end
`else
                        pc_o       <= merged_tgt;
                        redirect_o <= merged_vld;
                        misalign_o <= merged_vld && is_misaligned(merged_tgt[1:0]);
`endif
                    end else begin
                        state <= HOLD;
                        if (merged_vld) begin
                            pend_vld    <= 1'b1;
                            pend_tgt    <= merged_tgt;
                            pend_is_exc <= merged_is_exc;
                        end
                    end
                end
`ifdef NPC_DELAY_SLOT_EN
                // Delay slot has been fetched; the held target (or an exception) lands on the next advance.
                DSLOT: begin
                    if (advance) begin
                        pc_o       <= exc_req ? exc_addr : ds_tgt;
                        redirect_o <= 1'b1;
                        misalign_o <= is_misaligned(exc_req ? exc_addr[1:0] : ds_tgt[1:0]);
                        state      <= RUN;
                    end else if (exc_req) begin
                        ds_tgt <= exc_addr;
                    end
                end
`endif
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Table-driven bench for next_pc_unit; expectations flow through a scoreboard queue.
module tb_next_pc_unit;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        ack;
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] exc;
        logic [2:0]  br;
        logic        zf;
        logic        sf;
        logic [3:0]  jf;
        logic        xr;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_redir;
        logic        e_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        req;
        logic        redir;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] exc_addr;
    logic        br_beq, br_bne, br_bgez, zf, sf;
    logic        j_j, j_jal, j_jr, j_jalr;
    logic        exc_req;
    logic        if_ack;
    logic [31:0] pc_o;
    logic        if_req;
    logic        redirect_o;
    logic        misalign_o;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    next_pc_unit #(.XLEN(32), .RESET_VEC(32'h0040_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .inst       (inst),
        .rs_val     (rs_val),
        .exc_addr   (exc_addr),
        .br_beq     (br_beq),
        .br_bne     (br_bne),
        .br_bgez    (br_bgez),
        .zf         (zf),
        .sf         (sf),
        .j_j        (j_j),
        .j_jal      (j_jal),
        .j_jr       (j_jr),
        .j_jalr     (j_jalr),
        .exc_req    (exc_req),
        .if_ack     (if_ack),
        .pc_o       (pc_o),
        .if_req     (if_req),
        .redirect_o (redirect_o),
        .misalign_o (misalign_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input string n, input logic r, input logic st, input logic ak,
                       input logic [31:0] in, input logic [31:0] rs, input logic [31:0] ex,
                       input logic [2:0] b, input logic z, input logic s, input logic [3:0] jf,
                       input logic xr, input logic [31:0] epc, input logic ereq,
                       input logic er, input logic em);
        vec_t v;
        v.name = n; v.rst = r; v.stall = st; v.ack = ak; v.inst = in; v.rs = rs; v.exc = ex;
        v.br = b; v.zf = z; v.sf = s; v.jf = jf; v.xr = xr;
        v.e_pc = epc; v.e_req = ereq; v.e_redir = er; v.e_mis = em;
        vecs.push_back(v);
    endtask

    task automatic plain(input string n, input logic [31:0] epc);
        add(n, 0, 0, 1, 32'h0, 32'h0, 32'h0, 3'b000, 0, 0, 4'b0000, 0, epc, 1, 0, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst      = v.rst;
        stall    = v.stall;
        if_ack   = v.ack;
        inst     = v.inst;
        rs_val   = v.rs;
        exc_addr = v.exc;
        {br_beq, br_bne, br_bgez} = v.br;
        zf       = v.zf;
        sf       = v.sf;
        {j_j, j_jal, j_jr, j_jalr} = v.jf;
        exc_req  = v.xr;
        e.name = v.name; e.pc = v.e_pc; e.req = v.e_req; e.redir = v.e_redir; e.mis = v.e_mis;
        sb.push_back(e);
    endtask

    task automatic cmp(input string n, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%08h required=%08h", n, field, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "pc_o",       pc_o,              e.pc);
        cmp(e.name, "if_req",     32'(if_req),       32'(e.req));
        cmp(e.name, "redirect_o", 32'(redirect_o),   32'(e.redir));
        cmp(e.name, "misalign_o", 32'(misalign_o),   32'(e.mis));
    endtask

    initial begin
        // name, rst, stall, ack, inst, rs, exc, {beq,bne,bgez}, zf, sf, {j,jal,jr,jalr}, exc_req, pc, req, redir, mis
        add("reset0", 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 0, 0, 0);
        add("reset1", 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 0, 0, 0);
        add("boot",   0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 1, 0, 0);
`ifdef NPC_DELAY_SLOT_EN
        add("j_dslot",    0, 0, 1, 32'h0810_0040, 0, 0, 3'b000, 0, 0, 4'b1000, 0, 32'h0040_0004, 1, 0, 0);
        plain("ds_commit", 32'h0040_0100);
        vecs[$].e_redir = 1'b1;
        plain("after_ds", 32'h0040_0104);
        add("jr_dslot",   0, 0, 1, 0, 32'h0040_0300, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h0040_0108, 1, 0, 0);
        add("exc_in_ds",  0, 0, 1, 0, 0, 32'h8000_0180, 3'b000, 0, 0, 4'b0000, 1, 32'h8000_0180, 1, 1, 0);
        add("j_dslot2",   0, 0, 1, 32'h0810_0080, 0, 0, 3'b000, 0, 0, 4'b1000, 0, 32'h8000_0184, 1, 0, 0);
        add("rst_in_ds",  1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 0, 0, 0);
        add("boot2",      0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 1, 0, 0);
        plain("ds_discarded", 32'h0040_0004);
`else
        plain("seq1", 32'h0040_0004);
        plain("seq2", 32'h0040_0008);
        plain("seq3", 32'h0040_000C);
        plain("seq4", 32'h0040_0010);
        add("beq_back",    0, 0, 1, 32'h1000_FFFE, 0, 0, 3'b100, 1, 0, 4'b0000, 0, 32'h0040_000C, 1, 1, 0);
        plain("after_beq", 32'h0040_0010);
        add("bne_nt",      0, 0, 1, 32'h1400_0008, 0, 0, 3'b010, 1, 0, 4'b0000, 0, 32'h0040_0014, 1, 0, 0);
        add("bgez_t",      0, 0, 1, 32'h0401_0004, 0, 0, 3'b001, 0, 0, 4'b0000, 0, 32'h0040_0028, 1, 1, 0);
        add("bgez_nt",     0, 0, 1, 32'h0401_0004, 0, 0, 3'b001, 0, 1, 4'b0000, 0, 32'h0040_002C, 1, 0, 0);
        add("j",           0, 0, 1, 32'h0810_0040, 0, 0, 3'b000, 0, 0, 4'b1000, 0, 32'h0040_0100, 1, 1, 0);
        add("jal",         0, 0, 1, 32'h0C10_0050, 0, 0, 3'b000, 0, 0, 4'b0100, 0, 32'h0040_0140, 1, 1, 0);
        add("jr",          0, 0, 1, 0, 32'h0040_0200, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h0040_0200, 1, 1, 0);
        add("j_over_jr",   0, 0, 1, 32'h0810_0090, 32'h0040_0300, 0, 3'b000, 0, 0, 4'b1010, 0, 32'h0040_0240, 1, 1, 0);
        add("br_over_j",   0, 0, 1, 32'h0810_0010, 0, 0, 3'b100, 1, 0, 4'b1000, 0, 32'h0040_0284, 1, 1, 0);
        add("exc_over_br", 0, 0, 1, 32'h1000_0010, 0, 32'h8000_0180, 3'b100, 1, 0, 4'b0000, 1, 32'h8000_0180, 1, 1, 0);
        plain("after_exc", 32'h8000_0184);
        add("stall_jr",     0, 1, 1, 0, 32'h0040_0100, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h8000_0184, 1, 0, 0);
        add("stall_hold",   0, 1, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h8000_0184, 1, 0, 0);
        add("stall_ignore", 0, 1, 1, 32'h0810_0090, 0, 0, 3'b000, 0, 0, 4'b1000, 0, 32'h8000_0184, 1, 0, 0);
        add("stall_release", 0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0100, 1, 1, 0);
        plain("after_release", 32'h0040_0104);
        add("noack_jr",      0, 0, 0, 0, 32'h0040_0500, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h0040_0104, 1, 0, 0);
        add("noack_exc",     0, 0, 0, 0, 0, 32'h8000_0080, 3'b000, 0, 0, 4'b0000, 1, 32'h0040_0104, 1, 0, 0);
        plain("pend_exc_wins", 32'h8000_0080);
        vecs[$].e_redir = 1'b1;
        add("jr_misalign",   0, 0, 1, 0, 32'h0040_0102, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h0040_0102, 1, 1, 1);
        plain("after_misalign", 32'h0040_0106);
        add("jr_top",        0, 0, 1, 0, 32'hFFFF_FFFC, 0, 3'b000, 0, 0, 4'b0010, 0, 32'hFFFF_FFFC, 1, 1, 0);
        plain("wrap", 32'h0000_0000);
        add("noack_jr2",     0, 0, 0, 0, 32'h0040_0700, 0, 3'b000, 0, 0, 4'b0010, 0, 32'h0000_0000, 1, 0, 0);
        add("rst_in_hold",   1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 0, 0, 0);
        add("boot2",         0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4'b0000, 0, 32'h0040_0000, 1, 0, 0);
        plain("pend_discarded", 32'h0040_0004);
`endif

        applyStimulus(vecs[0]);
        @(posedge clk);
        #1;
        checkOutput();
        for (int i = 1; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
